// File: rtl/serial_addsub_unit.sv
// Digit-serial two's-complement add/subtract: DIGIT bits per clock over WIDTH/DIGIT cycles.
// Optional macro SERIAL_ADDSUB_SATURATE_EN clamps the result to signed max/min on overflow.
module serial_addsub_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             cy;
  logic             a_msb, b_msb;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] dig_ext;
  logic [WIDTH-1:0] res_nx;
  logic [WIDTH-1:0] res_fin;
  logic             ovf;
  logic             last;

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = start ? S_RUN : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // One digit of the ripple: low DIGIT bits of each operand plus the carried-in bit.
  always_comb begin
    dsum    = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + (DIGIT + 1)'(cy);
    dig_ext = WIDTH'(dsum[DIGIT-1:0]);
    res_nx  = (res_sr >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
    ovf     = (a_msb == b_msb) && (res_nx[WIDTH-1] != a_msb);
`ifdef SERIAL_ADDSUB_SATURATE_EN
    if (ovf) begin
      res_fin = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_fin = res_nx;
    end
`else
    res_fin = res_nx;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cy       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= mode ? ~b : b;
            cy    <= mode;
            a_msb <= a[WIDTH-1];
            b_msb <= mode ? ~b[WIDTH-1] : b[WIDTH-1];
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_nx;
          cy     <= dsum[DIGIT];
          cnt    <= cnt + 1'b1;
          // Outputs are committed only on the last digit so they hold steady through RUN.
          if (last) begin
            result   <= res_fin;
            carry    <= dsum[DIGIT];
            overflow <= ovf;
            zero     <= (res_fin == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench: three instances (DIGIT = 2, 1, 8) at WIDTH = 8 with hand-computed vectors.
module tb_serial_addsub_unit;

`ifdef SERIAL_ADDSUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  logic       mode;
  logic [7:0] a, b;

  logic       busy_w [3];
  logic       done_w [3];
  logic [7:0] res_w  [3];
  logic       carry_w[3];
  logic       ovf_w  [3];
  logic       zero_w [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 2 : (g == 1) ? 1 : 8;
    serial_addsub_unit #(.WIDTH(8), .DIGIT(DG)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .mode     (mode),
      .a        (a),
      .b        (b),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .result   (res_w[g]),
      .carry    (carry_w[g]),
      .overflow (ovf_w[g]),
      .zero     (zero_w[g])
    );
  end

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
    int         due;
  } exp_t;

  exp_t       sb[3][$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         bcnt[3];
  logic [7:0] last[3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nd(input int i);
    return (i == 0) ? 4 : (i == 1) ? 8 : 1;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)", nm, i, act, req, $time);
    end
  endtask

  // Monitor: pops an expectation whenever an instance pulses done.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        bcnt[i] = 0;
        last[i] = '0;
      end else begin
        if (busy_w[i]) begin
          bcnt[i]++;
          chk("hold_during_run", i, res_w[i], last[i]);
        end
        if (done_w[i]) begin
          if (sb[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done inst%0d: got done=1 expected no pending op", i);
          end else begin
            exp_t e;
            e = sb[i].pop_front();
            chk("result",   i, res_w[i],   e.res);
            chk("carry",    i, carry_w[i], e.c);
            chk("overflow", i, ovf_w[i],   e.v);
            chk("zero",     i, zero_w[i],  e.z);
            chk("latency",  i, cyc,        e.due);
            chk("busy_len", i, bcnt[i],    nd(i));
          end
          last[i] = res_w[i];
          bcnt[i] = 0;
        end
      end
    end
  end

  task automatic issue(input int i, input logic m, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] er, input logic ec, input logic ev, input logic ez);
    exp_t e;
    mode = m;
    a = av;
    b = bv;
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    e.res = er; e.c = ec; e.v = ev; e.z = ez; e.due = cyc + nd(i);
    sb[i].push_back(e);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_w[i]) return;
    end
    total++;
    bad++;
    $display("FAIL done_timeout inst%0d: got no done expected done within 40 cycles", i);
  endtask

  initial begin
    rst = 1'b1;
    start_v = '0;
    mode = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy",   i, busy_w[i],  0);
      chk("rst_done",   i, done_w[i],  0);
      chk("rst_result", i, res_w[i],   0);
      chk("rst_carry",  i, carry_w[i], 0);
      chk("rst_ovf",    i, ovf_w[i],   0);
      chk("rst_zero",   i, zero_w[i],  0);
    end
    #1 rst = 1'b0;
    @(negedge clk);

    issue(0, 1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0, 1'b0);
    wait_done(0); @(negedge clk);
    issue(0, 1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0);
    wait_done(0); @(negedge clk);
    issue(0, 1'b1, 8'h80, 8'h01, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1, 1'b0);
    wait_done(0); @(negedge clk);
    issue(0, 1'b0, 8'h7F, 8'h01, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b0);
    wait_done(0); @(negedge clk);
    issue(0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_done(0); @(negedge clk);

    // Start during busy must be ignored; start in the done cycle chains a second op.
    issue(0, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    mode = 1'b1; a = 8'hAA; b = 8'h01; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0);
    issue(0, 1'b0, 8'h40, 8'h40, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b0);
    wait_done(0); @(negedge clk);

    // Reset in the middle of RUN: outputs drop at once, no done follows.
    mode = 1'b0; a = 8'h01; b = 8'h01; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy",   0, busy_w[0],  0);
    chk("midrst_done",   0, done_w[0],  0);
    chk("midrst_result", 0, res_w[0],   0);
    chk("midrst_carry",  0, carry_w[0], 0);
    chk("midrst_ovf",    0, ovf_w[0],   0);
    chk("midrst_zero",   0, zero_w[0],  0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_after_rst", 0, busy_w[0], 0);

    issue(0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_done(0); @(negedge clk);

    issue(1, 1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0, 1'b0);
    wait_done(1); @(negedge clk);
    issue(1, 1'b0, 8'h7F, 8'h01, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b0);
    wait_done(1); @(negedge clk);
    issue(2, 1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0, 1'b0);
    wait_done(2); @(negedge clk);
    issue(2, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_done(2); @(negedge clk);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("pending_ops", i, sb[i].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
